// File: rtl/color_palette_q.sv
// Palette lookup with a CPU write queue, blanking-deferred commit, reset-time
// clear sequencer and a 2-cycle registered video read port.
module color_palette_q #(
    parameter int IDX_W   = 5,
    parameter int COLOR_W = 9,
    parameter int QDEPTH  = 4,
    parameter bit DEFER   = 1'b1
) (
    input  logic                     CLK10,
    input  logic                     RESET,
    input  logic                     CLK5n,
    input  logic                     CRAMn,
    input  logic [IDX_W-1:0]         WADDR,
    input  logic [COLOR_W-1:0]       WDATA,
    input  logic [IDX_W-1:0]         PIX_IDX,
    input  logic                     BLANK,
    output logic [COLOR_W-1:0]       o,
    output logic [$clog2(QDEPTH):0]  QLEVEL,
    output logic                     BUSY,
    output logic                     FORCED
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int LVL_W   = PTR_W + 1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   clr_cnt;
    logic               req_done;
    logic               req, q_full, forced, drain, enq;
    logic [PTR_W-1:0]   head, tail;
    logic [LVL_W-1:0]   level;
    logic [IDX_W-1:0]   q_addr [QDEPTH];
    logic [COLOR_W-1:0] q_data [QDEPTH];
    logic [COLOR_W-1:0] ram    [ENTRIES];
    logic [IDX_W-1:0]   pix_s1;
    logic               blank_s1;

    assign BUSY   = (state == S_CLEAR);
    assign QLEVEL = level;

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        req       = !CRAMn && !CLK5n && !req_done;
        q_full    = (level == LVL_W'(QDEPTH));
        forced    = q_full && req;
        drain     = (state == S_RUN) && (level != '0) && (!DEFER || BLANK || forced);
        // A full queue only accepts when the head leaves on the same edge.
        enq       = req && (!q_full || drain);
        state_nxt = state;
        if (state == S_CLEAR && clr_cnt == '1)
            state_nxt = S_RUN;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK10 or posedge RESET) begin
        if (RESET)
            state <= S_CLEAR;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK10 or posedge RESET) begin
        if (RESET) begin
            clr_cnt  <= '0;
            req_done <= 1'b0;
            head     <= '0;
            tail     <= '0;
            level    <= '0;
            FORCED   <= 1'b0;
        end else begin
            // Once a request fires, stay quiet until CRAMn returns high.
            req_done <= !CRAMn && (req_done || !CLK5n);
            if (state == S_CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            if (enq)
                tail <= tail + 1'b1;
            if (drain)
                head <= head + 1'b1;
            case ({enq, drain})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            FORCED <= drain && forced && !BLANK;
        end
    end

    always_ff @(posedge CLK10) begin
        if (enq) begin
            q_addr[tail] <= WADDR;
            q_data[tail] <= WDATA;
        end
    end

    // NOTE: storage arrays have no reset; the palette is zeroed by the clear sequencer instead.
    always_ff @(posedge CLK10) begin
        if (state == S_CLEAR)
            ram[clr_cnt] <= '0;
        else if (drain)
            ram[q_addr[head]] <= q_data[head];
    end

    // Lookup reads the pre-write contents when a drain hits the same index.
    always_ff @(posedge CLK10 or posedge RESET) begin
        if (RESET) begin
            pix_s1   <= '0;
            blank_s1 <= 1'b0;
            o        <= '0;
        end else begin
            pix_s1   <= PIX_IDX;
            blank_s1 <= BLANK;
            o        <= (blank_s1 || BUSY) ? '0 : ram[pix_s1];
        end
    end

endmodule

// File: tb/tb_color_palette_q.sv
// Directed bench for color_palette_q: one deferred-drain instance, one
// immediate-drain instance sharing the same stimulus.
module tb_color_palette_q;

    typedef struct {
        logic [4:0] idx;
        logic [8:0] data;
    } vec_t;

    logic       CLK10 = 1'b0;
    logic       RESET = 1'b1;
    logic       CLK5n = 1'b1;
    logic       CRAMn = 1'b1;
    logic       BLANK = 1'b0;
    logic [4:0] WADDR = '0;
    logic [4:0] PIX_IDX = '0;
    logic [8:0] WDATA = '0;

    logic [8:0] o0, o1;
    logic [2:0] qlevel0, qlevel1;
    logic       busy0, busy1, forced0, forced1;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t wr_tab [5];
    vec_t rd_pre [2];
    vec_t rd_post[6];

    color_palette_q #(.IDX_W(5), .COLOR_W(9), .QDEPTH(4), .DEFER(1'b1)) u_dut (
        .CLK10(CLK10), .RESET(RESET), .CLK5n(CLK5n), .CRAMn(CRAMn),
        .WADDR(WADDR), .WDATA(WDATA), .PIX_IDX(PIX_IDX), .BLANK(BLANK),
        .o(o0), .QLEVEL(qlevel0), .BUSY(busy0), .FORCED(forced0)
    );

    color_palette_q #(.IDX_W(5), .COLOR_W(9), .QDEPTH(4), .DEFER(1'b0)) u_dut_nd (
        .CLK10(CLK10), .RESET(RESET), .CLK5n(CLK5n), .CRAMn(CRAMn),
        .WADDR(WADDR), .WDATA(WDATA), .PIX_IDX(PIX_IDX), .BLANK(BLANK),
        .o(o1), .QLEVEL(qlevel1), .BUSY(busy1), .FORCED(forced1)
    );

    always #5 CLK10 = ~CLK10;
    always @(negedge CLK10) CLK5n = ~CLK5n;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK10);
        #1;
    endtask

    // Returns just after the edge on which the request was raised, CRAMn back high.
    task automatic cpu_write(input logic [4:0] addr, input logic [8:0] data);
        logic hit;
        CRAMn = 1'b1;
        step();
        WADDR = addr;
        WDATA = data;
        CRAMn = 1'b0;
        hit   = 1'b0;
        for (int i = 0; i < 4 && !hit; i++) begin
            @(negedge CLK10);
            #1;
            hit = !CLK5n;
            @(posedge CLK10);
            #1;
        end
        CRAMn = 1'b1;
        if (!hit) begin
            n_fail++;
            $display("FAIL cpu_write: no CLK5n low phase within bound");
        end
    endtask

    // Steps until BUSY drops, checking o stays 0; returns the edge count.
    task automatic count_busy(output int n, output logic o_bad);
        n     = 0;
        o_bad = 1'b0;
        while (busy0 && n < 100) begin
            step();
            n++;
            if (o0 !== 9'h000 || o1 !== 9'h000)
                o_bad = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   n_busy;
        logic o_bad;

        wr_tab[0] = '{5'd0, 9'h101};
        wr_tab[1] = '{5'd1, 9'h102};
        wr_tab[2] = '{5'd2, 9'h103};
        wr_tab[3] = '{5'd3, 9'h104};
        wr_tab[4] = '{5'd4, 9'h105};
        rd_pre[0] = '{5'd0, 9'h101};
        rd_pre[1] = '{5'd1, 9'h000};
        rd_post[0] = '{5'd1, 9'h102};
        rd_post[1] = '{5'd2, 9'h103};
        rd_post[2] = '{5'd3, 9'h104};
        rd_post[3] = '{5'd4, 9'h105};
        rd_post[4] = '{5'd5, 9'h033};
        rd_post[5] = '{5'd0, 9'h101};

        // 1: reset values and clear timing
        PIX_IDX = 5'd7;
        #23;
        check("rst_o", 16'(o0), 16'h0);
        check("rst_qlevel", 16'(qlevel0), 16'h0);
        check("rst_busy", 16'(busy0), 16'h1);
        check("rst_forced", 16'(forced0), 16'h0);
        RESET = 1'b0;
        count_busy(n_busy, o_bad);
        check("clear_edges", 16'(n_busy), 16'd32);
        check("clear_o_zero", 16'(o_bad), 16'h0);
        check("clear_busy1", 16'(busy1), 16'h0);
        step();
        step();
        check("cleared_ram_o0", 16'(o0), 16'h0);
        check("cleared_ram_o1", 16'(o1), 16'h0);

        // 2: deferred write
        BLANK = 1'b0;
        cpu_write(5'd3, 9'h1A5);
        check("defer_qlevel", 16'(qlevel0), 16'h1);
        PIX_IDX = 5'd3;
        step();
        step();
        check("defer_old_o", 16'(o0), 16'h0);
        check("defer_held", 16'(qlevel0), 16'h1);
        BLANK = 1'b1;
        step();
        check("defer_drained", 16'(qlevel0), 16'h0);
        BLANK = 1'b0;
        step();
        check("defer_blanked_o", 16'(o0), 16'h0);
        step();
        check("defer_new_o", 16'(o0), 16'h1A5);

        // 3: long strobe yields a single request
        CRAMn = 1'b1;
        step();
        WADDR = 5'd5;
        WDATA = 9'h033;
        CRAMn = 1'b0;
        repeat (8) step();
        check("long_strobe_q", 16'(qlevel0), 16'h1);
        CRAMn = 1'b1;
        step();
        check("long_strobe_q2", 16'(qlevel0), 16'h1);
        BLANK = 1'b1;
        step();
        check("long_strobe_drain", 16'(qlevel0), 16'h0);
        BLANK = 1'b0;

        // 4: forced drain on full queue
        for (int i = 0; i < 4; i++)
            cpu_write(wr_tab[i].idx, wr_tab[i].data);
        check("full_qlevel", 16'(qlevel0), 16'h4);
        check("full_no_forced", 16'(forced0), 16'h0);
        cpu_write(wr_tab[4].idx, wr_tab[4].data);
        check("forced_pulse", 16'(forced0), 16'h1);
        check("forced_qlevel", 16'(qlevel0), 16'h4);
        step();
        check("forced_pulse_end", 16'(forced0), 16'h0);
        check("forced_qlevel_hold", 16'(qlevel0), 16'h4);
        for (int i = 0; i < 2; i++) begin
            PIX_IDX = rd_pre[i].idx;
            step();
            step();
            check($sformatf("forced_rd_idx%0d", rd_pre[i].idx), 16'(o0), 16'(rd_pre[i].data));
        end
        BLANK = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            step();
            check($sformatf("drain_level_%0d", k), 16'(qlevel0), 16'(k));
        end
        BLANK = 1'b0;
        for (int i = 0; i < 6; i++) begin
            PIX_IDX = rd_post[i].idx;
            step();
            step();
            check($sformatf("drain_rd_idx%0d", rd_post[i].idx), 16'(o0), 16'(rd_post[i].data));
        end

        // 5: read/write collision on the immediate-drain instance
        PIX_IDX = 5'd9;
        cpu_write(5'd9, 9'h055);
        step();
        step();
        check("coll_setup", 16'(o1), 16'h055);
        cpu_write(5'd9, 9'h0AA);
        check("coll_pre", 16'(o1), 16'h055);
        step();
        check("coll_old", 16'(o1), 16'h055);
        step();
        check("coll_new", 16'(o1), 16'h0AA);

        // 6: reset mid-operation
        check("pre_reset_q", 16'(qlevel0), 16'h2);
        RESET = 1'b1;
        #2;
        check("reset_q_empty", 16'(qlevel0), 16'h0);
        RESET = 1'b0;
        cpu_write(5'd10, 9'h011);
        cpu_write(5'd11, 9'h022);
        check("clear_enq_q", 16'(qlevel0), 16'h2);
        check("clear_enq_busy", 16'(busy0), 16'h1);
        repeat (3) step();
        check("clear_no_drain", 16'(qlevel0), 16'h2);
        #2;
        RESET = 1'b1;
        #1;
        check("midclr_q", 16'(qlevel0), 16'h0);
        check("midclr_busy", 16'(busy0), 16'h1);
        check("midclr_o", 16'(o0), 16'h0);
        #1;
        RESET = 1'b0;
        count_busy(n_busy, o_bad);
        check("reclear_edges", 16'(n_busy), 16'd32);
        check("reclear_o_zero", 16'(o_bad), 16'h0);
        check("reclear_q", 16'(qlevel0), 16'h0);
        PIX_IDX = 5'd3;
        step();
        step();
        check("reclear_ram", 16'(o0), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/color_palette_q.md
Name: color_palette_q

Overview:
- Parametrised palette lookup block with N entries of COLOR_W-bit colour words.
- The CPU writes colour words with the same active-low strobe qualified by CLK5n that the existing colour memory path uses.
- Each write goes into a small write-queue FIFO. When DEFER=1 the queue is committed only during blanking, so a palette update never tears mid-line.
- The video side uses a separate read port: 2-cycle registered lookup, with blanking forced to black.
- After reset the block clears the whole palette to 0 with its own sequencer before normal operation begins.

Parameters:
- IDX_W, 5, palette index width; ENTRIES = 2**IDX_W.
- COLOR_W, 9, colour word width.
- QDEPTH, 4, write-queue depth; must be a power of 2 and at least 2.
- DEFER, 1, 1 = drain the queue only while BLANK=1 (or when forced); 0 = drain whenever the queue is non-empty.

Ports:
- CLK10  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CLK5n  in  1  half-rate phase; write qualifier.
- CRAMn  in  1  active-low CPU palette write select.
- WADDR  in  IDX_W  CPU palette index.
- WDATA  in  COLOR_W  CPU colour word.
- PIX_IDX  in  IDX_W  video pixel index.
- BLANK  in  1  1 = blanking interval.
- o  out  COLOR_W  registered colour output.
- QLEVEL  out  log2(QDEPTH)+1  current queue occupancy.
- BUSY  out  1  1 while the clear sequence runs.
- FORCED  out  1  one-cycle pulse when a forced drain happens while BLANK=0.

Behaviour:
- Reset (asynchronous):
  - FSM -> CLEAR, clear counter = 0, queue empty (QLEVEL=0).
  - o=0, BUSY=1, FORCED=0.
  - Internal strobe-edge history set to "idle".
- Write request detection:
  - A request is raised on the first edge where CRAMn=0 and CLK5n=0 within a given CRAMn-low period. Exactly one request per CRAMn low pulse, however long it lasts.
  - WADDR/WDATA are sampled at that edge and enqueued at that same edge.
- Queue:
  - Circular FIFO with head and tail pointers; wrap-around is modulo QDEPTH.
  - Enqueue and dequeue may happen on the same edge; QLEVEL is then unchanged.
- Drain condition, evaluated each edge in state RUN with QLEVEL>0:
  - Normal: (DEFER=0) or BLANK=1.
  - Forced: QLEVEL==QDEPTH and a new request occurs on this edge, regardless of BLANK.
  - A forced drain writes the head entry and enqueues the new one on the same edge, so nothing is ever dropped.
  - FORCED pulses high for one cycle only if the forced drain occurred with BLANK=0.
- Drain action: RAM[head.addr] <= head.data; exactly one entry per edge.
- FSM:
  - CLEAR: each edge writes RAM[clear counter] <= 0 and increments the counter. After the edge that writes ENTRIES-1, go to RUN and set BUSY=0. The CLEAR phase takes exactly ENTRIES edges.
    - Requests are still enqueued during CLEAR but never drained.
    - If the queue is full during CLEAR, further requests are discarded. This is the only loss case.
  - RUN: drain rules as above; remain in RUN until RESET.
  - RESET asserted mid-CLEAR or mid-RUN restarts the CLEAR sequence and empties the queue.
- Video pipeline:
  - Stage 1 registers PIX_IDX and BLANK.
  - Stage 2 sets o <= (BLANK_s1 || BUSY) ? 0 : RAM[PIX_IDX_s1].
  - Latency: PIX_IDX at edge k appears on o after edge k+1.
- Collision:
  - A read and a drain write to the same index on the same edge return the OLD data (read-before-write).
  - The new value is visible on the next lookup.
- Widths: all indices unsigned; no arithmetic other than the pointer and counter increments, which wrap.

Test Plan:
1. Reset-clear timing:
   - Stimulus: assert RESET, release; hold BLANK=0, PIX_IDX=7.
   - Required: BUSY=1 for exactly 32 edges (IDX_W=5), o=0 throughout; after CLEAR, o=0 (cleared RAM).
2. Deferred write (DEFER=1):
   - Stimulus: with BLANK=0, write idx 3 = 0x1A5.
   - Required: QLEVEL=1; o for PIX_IDX=3 stays at the old value 0.
   - Then: raise BLANK for 1 cycle -> QLEVEL=0. After BLANK=0, PIX_IDX=3 gives o=0x1A5 two edges later.
3. Long strobe:
   - Stimulus: hold CRAMn=0 for 8 CLK10 cycles (4 CLK5n low phases).
   - Required: exactly one enqueue, QLEVEL=1.
4. Forced drain:
   - Stimulus: with BLANK=0, queue 4 writes (idx 0..3 = 0x101..0x104), then a 5th (idx 4 = 0x105).
   - Required:
     - FORCED pulses once.
     - RAM[0]=0x101 and QLEVEL stays 4.
     - Draining later during blanking delivers idx 1..4 in order.
5. Collision:
   - Stimulus: DEFER=0, PIX_IDX=9 steady, RAM[9]=0x055; write idx 9 = 0x0AA.
   - Required:
     - The lookup sampled on the drain edge outputs 0x055.
     - The following lookup outputs 0x0AA.
6. Reset mid-operation:
   - Stimulus: 2 entries queued plus RESET asserted mid-CLEAR.
   - Required: QLEVEL=0 immediately, clear counter restarts, BUSY=1 for a full 32 edges again.
